// File: rtl/aes_sub_bytes_seq.sv
// Iterative AES SubBytes engine: takes one 128-bit state and substitutes it
// LANES bytes per clock through a bank of forward S-boxes. It then holds the
// result until downstream takes it.
//
// Handshake: a state transfers on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE. out_valid is high only in DONE and
// holds until out_ready is seen. Each side ignores its partner signal while
// its own flag is low.

// Forward FIPS-197 S-box: a byte in, its SubBytes image out (pure lookup).
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y = SBOX[a];
endmodule

module aes_sub_bytes_seq #(
  parameter int LANES = 4  // bytes per clock: 1, 2, 4, 8 or 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [127:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [127:0] out_data,
  input  logic         out_ready,
  output logic         busy
);
  localparam int GROUPS = 16 / LANES;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(GROUPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [127:0]   work_q, work_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;

  logic [7:0] lane_in  [LANES];
  logic [7:0] lane_out [LANES];

  // Pick the current group's bytes; byte 0 sits in the top of the word.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = work_q[8*(15 - (int'(cnt_q)*LANES + l)) +: 8];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox u_sbox (
      .a (lane_in[g]),
      .y (lane_out[g])
    );
  end

  // Next state: accept in IDLE, substitute one group per RUN cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int l = 0; l < LANES; l++) begin
          work_d[8*(15 - (int'(cnt_q)*LANES + l)) +: 8] = lane_out[l];
        end
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // FSM, group counter, working register and handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = !in_ready_q;
  assign out_data  = work_q;
endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Bench for aes_sub_bytes_seq: a LANES=4 instance checked every cycle against
// a transaction model, plus LANES=1/2/8/16 instances for latency and result.
module tb_aes_sub_bytes_seq;
  localparam logic [127:0] VEC  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] VRES = 128'h638293c31bfc33f5c4eeacea4bc12816;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic [127:0] in_data  = '0;
  logic         out_ready = 1'b1;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_data;

  aes_sub_bytes_seq #(.LANES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy)
  );

  logic [3:0]   x_in_valid = '0;
  logic         x_out_ready = 1'b1;
  logic [3:0]   x_in_ready, x_out_valid, x_busy;
  logic [127:0] x_out_data [4];

  for (genvar g = 0; g < 4; g++) begin : g_x
    aes_sub_bytes_seq #(.LANES((g < 2) ? (1 << g) : (1 << (g + 1)))) u_x (
      .clk(clk), .rst(rst), .in_valid(x_in_valid[g]), .in_data(in_data),
      .in_ready(x_in_ready[g]), .out_valid(x_out_valid[g]), .out_data(x_out_data[g]),
      .out_ready(x_out_ready), .busy(x_busy[g])
    );
  end

  // ---------------- counters / checks ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference S-box from GF(2^8) arithmetic ----------------
  logic [7:0] sbox_m [256];
  logic [7:0] inv_m  [256];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 8'h00) begin
      for (int c = 1; c < 256; c++) begin
        if (gf_mul(x, 8'(c)) == 8'h01) inv = 8'(c);
      end
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes_m(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*(15-i) +: 8] = sbox_m[d[8*(15-i) +: 8]];
    return r;
  endfunction

  // ---------------- transaction model of the LANES=4 instance ----------------
  // phase 0 = waiting for a state, 1 = computing, 2 = result offered.
  int           m_phase = 0;
  int           m_left  = 0;
  logic [127:0] m_out   = '0;
  logic [127:0] exp_q[$];
  logic         chk_en  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_out   = '0;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: if (in_valid) begin
             exp_q.push_back(sub_bytes_m(in_data));
             m_left  = 4;
             m_phase = 1;
           end
        1: begin
             m_left--;
             if (m_left == 0) begin
               m_out   = exp_q[0];
               m_phase = 2;
             end
           end
        default: if (out_ready) begin
             void'(exp_q.pop_front());
             m_phase = 0;
           end
      endcase
    end
  end

  // Compare process: handshake flags always, data whenever it is defined.
  always @(negedge clk) begin
    if (chk_en) begin
      check_bit("cmp_in_ready",  in_ready,  m_phase == 0);
      check_bit("cmp_out_valid", out_valid, m_phase == 2);
      check_bit("cmp_busy",      busy,      m_phase != 0);
      if (m_phase != 1) check("cmp_out_data", out_data, m_out);
    end
  end

  // ---------------- driver tasks (entered and left at a falling edge) ----------------
  task automatic run_one(input string name, input logic [127:0] d, input logic [127:0] exp);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (1) begin
      @(negedge clk);
      n++;
      in_valid = 1'b0;
      if (out_valid || n > 64) break;
    end
    check_bit({name, "_seen"}, out_valid, 1'b1);
    check_int({name, "_latency"}, n - 1, 4);
    check({name, "_data"}, out_data, exp);
    @(negedge clk);
    check_bit({name, "_drop"}, out_valid, 1'b0);
    check_bit({name, "_ready"}, in_ready, 1'b1);
  endtask

  task automatic run_x(input int g, input int lanes);
    int n = 0;
    x_in_valid[g] = 1'b1;
    in_data = VEC;
    while (1) begin
      @(negedge clk);
      n++;
      x_in_valid[g] = 1'b0;
      if (x_out_valid[g] || n > 64) break;
    end
    check_bit($sformatf("x%0d_seen", lanes), x_out_valid[g], 1'b1);
    check_int($sformatf("x%0d_latency", lanes), n - 1, 16 / lanes);
    check($sformatf("x%0d_data", lanes), x_out_data[g], VRES);
    @(negedge clk);
    check_bit($sformatf("x%0d_drop", lanes), x_out_valid[g], 1'b0);
    check_bit($sformatf("x%0d_ready", lanes), x_in_ready[g], 1'b1);
    check_bit($sformatf("x%0d_busy", lanes), x_busy[g], 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] held;
    int n;
    for (int v = 0; v < 256; v++) sbox_m[v] = sbox_calc(8'(v));
    for (int v = 0; v < 256; v++) inv_m[sbox_m[v]] = 8'(v);

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_bit("rst_in_ready", in_ready, 1'b1);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check("rst_out_data", out_data, '0);
    chk_en = 1'b1;
    rst = 1'b0;

    // Reference vector and uniform states, against hand-computed results.
    run_one("vec", VEC, VRES);
    run_one("all00", {16{8'h00}}, {16{8'h63}});
    run_one("all53", {16{8'h53}}, {16{8'hed}});
    run_one("allff", {16{8'hff}}, {16{8'h16}});

    // Back-pressure: result must sit still while new inputs are offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = VEC;
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      in_valid = 1'b0;
      if (out_valid || n > 64) break;
    end
    check_bit("bp_seen", out_valid, 1'b1);
    held = out_data;
    check("bp_first", held, VRES);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check_bit("bp_valid", out_valid, 1'b1);
      check("bp_data", out_data, held);
      check_bit("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    check_bit("bp_release_valid", out_valid, 1'b0);
    check_bit("bp_release_ready", in_ready, 1'b1);
    check("bp_release_data", out_data, VRES);

    // Reset two cycles into RUN, then a fresh state straight after release.
    in_valid = 1'b1;
    in_data  = {16{8'h53}};
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_bit("abort_out_valid", out_valid, 1'b0);
    check("abort_out_data", out_data, '0);
    check_bit("abort_in_ready", in_ready, 1'b1);
    check_bit("abort_busy", busy, 1'b0);
    @(negedge clk);
    check_bit("abort_hold_valid", out_valid, 1'b0);
    rst = 1'b0;
    run_one("after_rst", VEC, VRES);

    // Other lane widths: same result, latency 16/LANES.
    run_x(0, 1);
    run_x(1, 2);
    run_x(2, 8);
    run_x(3, 16);

    // Every byte value replicated across the state.
    for (int v = 0; v < 256; v++) begin
      run_one($sformatf("sweep%02h", v), {16{8'(v)}}, sub_bytes_m({16{8'(v)}}));
      for (int i = 0; i < 16; i++) begin
        check_int("sweep_inv", int'(inv_m[out_data[8*(15-i) +: 8]]), v);
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
